usb_link_ctl: RTL and testbench

- Parametrised successor to the USB PHY link-state controller.
- Runs a configurable table of ULPI register writes on enable and disable.
- Tracks bus state: USB reset (SE0), suspend (idle J) and resume. Drives usb_reset and usb_suspend to the USB core.
- Sits between the top-level enable and the ULPI register-access port.

---
 rtl/usb_link_pkg.sv | 25 ++
 rtl/usb_link_ctl_reg_wr.sv | 91 +++++++++
 rtl/usb_link_ctl.sv | 181 ++++++++++++++++++
 tb/tb_usb_link_ctl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_link_pkg.sv
// Shared encodings for the USB link-state controller.
// Optional reg_rdy timeout/retry: USB_LINK_REG_TIMEOUT_EN.
package usb_link_pkg;

  typedef enum logic [2:0] {
    DISCONNECTED,
    INIT,
    FUNC,
    RESET,
    IDLE,
    SUSPEND
  } link_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WR,
    R_WAIT,
    R_DONE
  } reg_state_t;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

endpackage

// File: rtl/usb_link_ctl_reg_wr.sv
// ULPI single-register write engine with handshake.
// USB_LINK_REG_TIMEOUT_EN adds a reg_rdy timeout and retry.
module usb_ulpi_reg_wr
  import usb_link_pkg::*;
#(
  parameter int REG_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       reg_rdy,
  output logic       reg_en,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_din,
  output logic       done,
  output logic       reg_error
);

  reg_state_t state, state_nxt;
  logic       load;
  logic       expired;

`ifdef USB_LINK_REG_TIMEOUT_EN
  localparam int TW = $clog2(REG_TIMEOUT + 1);

  logic [TW-1:0] wcnt;

  assign expired = (wcnt == TW'(REG_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= '0;
      reg_error <= 1'b0;
    end else begin
      if (state != R_WAIT) wcnt <= '0;
      else                 wcnt <= wcnt + 1'b1;
      if (state == R_WAIT && !reg_rdy && expired)
        reg_error <= 1'b1;
    end
  end
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(REG_TIMEOUT);
  assign expired        = 1'b0;
  assign reg_error      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      R_IDLE: begin
        if (start) begin
          state_nxt = R_WR;
          load      = 1'b1;
        end
      end
      R_WR:   state_nxt = R_WAIT;
      R_WAIT: begin
        // a retry reissues the held entry unchanged
        if (reg_rdy)      state_nxt = R_DONE;
        else if (expired) state_nxt = R_WR;
      end
      R_DONE: state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= R_IDLE;
      reg_addr <= '0;
      reg_din  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        reg_addr <= addr;
        reg_din  <= data;
      end
    end
  end

  assign reg_en = (state == R_WR);
  assign reg_we = reg_en;
  assign done   = (state == R_DONE);

endmodule

// File: rtl/usb_link_ctl.sv
// USB link-state controller: ULPI setup tables and bus state.
// Optional reg_rdy timeout/retry: USB_LINK_REG_TIMEOUT_EN.
module usb_link_ctl
  import usb_link_pkg::*;
#(
  parameter int          NUM_INIT       = 1,
  parameter logic [31:0] INIT_ADDRS     = 32'h0000000A,
  parameter logic [31:0] INIT_DATA      = 32'h00000000,
  parameter logic [7:0]  FUNC_ADDR      = 8'h04,
  parameter logic [7:0]  FUNC_EN_VAL    = 8'h45,
  parameter logic [7:0]  FUNC_DIS_VAL   = 8'h49,
  parameter int          RESET_CYCLES   = 150,
  parameter int          SUSPEND_CYCLES = 180000,
  parameter int          CNT_W          = 18,
  parameter int          REG_TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_enable,
  input  logic [1:0] line_state,
  output logic       usb_reset,
  output logic       usb_suspend,
  output logic       busy,
  output logic       reg_error,
  output logic       reg_en,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_din,
  input  logic       reg_rdy,
  input  logic [7:0] reg_dout
);

  localparam logic [1:0] IDX_LAST = 2'(NUM_INIT - 1);

  link_state_t state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        mode, mode_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]  ls_q;
  logic        in_link;
  logic        se0_hit;
  logic        j_hit;
  logic        done;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        unused_dout;

  assign unused_dout = ^reg_dout;

  assign in_link = (state == IDLE) || (state == SUSPEND);
  assign busy    = (state == INIT) || (state == FUNC);

  assign se0_hit = (line_state == LS_SE0) &&
                   (cnt >= CNT_W'(RESET_CYCLES));
  assign j_hit   = (line_state == LS_J) &&
                   (cnt >= CNT_W'(SUSPEND_CYCLES));

  assign wr_addr = (state == FUNC) ? FUNC_ADDR :
                   INIT_ADDRS[{idx, 3'b000} +: 8];
  assign wr_data = (state == FUNC) ?
                   (mode ? FUNC_EN_VAL : FUNC_DIS_VAL) :
                   INIT_DATA[{idx, 3'b000} +: 8];

  usb_ulpi_reg_wr #(
    .REG_TIMEOUT (REG_TIMEOUT)
  ) u_reg_wr (
    .clk       (clk),
    .rst       (rst),
    .start     (busy),
    .addr      (wr_addr),
    .data      (wr_data),
    .reg_rdy   (reg_rdy),
    .reg_en    (reg_en),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_din   (reg_din),
    .done      (done),
    .reg_error (reg_error)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mode_nxt  = mode;
    unique case (state)
      DISCONNECTED: begin
        if (usb_enable) begin
          state_nxt = INIT;
          mode_nxt  = 1'b1;
          idx_nxt   = '0;
        end
      end
      INIT: begin
        if (done) begin
          if (idx == IDX_LAST) state_nxt = FUNC;
          else                 idx_nxt   = idx + 2'd1;
        end
      end
      FUNC: begin
        // a late disable reruns the table rather than being lost
        if (done) begin
          if (!mode) begin
            state_nxt = DISCONNECTED;
          end else if (usb_enable) begin
            state_nxt = RESET;
          end else begin
            state_nxt = INIT;
            mode_nxt  = 1'b0;
            idx_nxt   = '0;
          end
        end
      end
      RESET: begin
        if (!usb_enable) begin
          state_nxt = INIT;
          mode_nxt  = 1'b0;
          idx_nxt   = '0;
        end else if (line_state == LS_J) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (!usb_enable) begin
          state_nxt = INIT;
          mode_nxt  = 1'b0;
          idx_nxt   = '0;
        end else if (se0_hit) begin
          state_nxt = RESET;
        end else if (j_hit) begin
          state_nxt = SUSPEND;
        end
      end
      SUSPEND: begin
        if (!usb_enable) begin
          state_nxt = INIT;
          mode_nxt  = 1'b0;
          idx_nxt   = '0;
        end else if (line_state == LS_K) begin
          state_nxt = IDLE;
        end else if (se0_hit) begin
          state_nxt = RESET;
        end
      end
      default: state_nxt = DISCONNECTED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DISCONNECTED;
      idx   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      mode  <= mode_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      ls_q <= LS_SE0;
    end else begin
      ls_q <= line_state;
      if (!in_link || line_state != ls_q) cnt <= '0;
      else if (cnt != '1)                 cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      usb_reset   <= 1'b1;
      usb_suspend <= 1'b0;
    end else begin
      usb_reset   <= !in_link;
      usb_suspend <= (state == SUSPEND);
    end
  end

endmodule

// File: tb/tb_usb_link_ctl.sv
// Self-checking bench for usb_link_ctl.
// Timeout scenario runs when USB_LINK_REG_TIMEOUT_EN is defined.
module tb_usb_link_ctl;

  localparam int RC = 150;
  localparam int SC = 100;
  localparam int TO = 8;
`ifdef USB_LINK_REG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int L_OFF  = 0;
  localparam int L_SEQ  = 1;
  localparam int L_RST  = 2;
  localparam int L_IDLE = 3;
  localparam int L_SUSP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       usb_enable = 1'b0;
  logic [1:0] line_state = 2'b01;
  logic       usb_reset, usb_suspend, busy, reg_error;
  logic       reg_en, reg_we;
  logic [7:0] reg_addr, reg_din;
  logic       reg_rdy = 1'b0;
  logic [7:0] reg_dout = 8'h00;

  bit hold_rdy  = 1'b0;
  bit early_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] en_list[$]  = '{16'h0A00, 16'h0B11, 16'h0445};
  logic [15:0] dis_list[$] = '{16'h0A00, 16'h0B11, 16'h0449};
  logic [15:0] obs[$];

  int          m_link;
  bit          m_enabling;
  logic [15:0] m_q[$];
  int          m_wph;
  int          m_wt;
  logic [15:0] m_cur;
  int          m_run;
  logic [1:0]  m_prev;
  bit          m_ureset, m_susp, m_err;

  usb_link_ctl #(
    .NUM_INIT       (2),
    .INIT_ADDRS     (32'h00000B0A),
    .INIT_DATA      (32'h00001100),
    .FUNC_ADDR      (8'h04),
    .FUNC_EN_VAL    (8'h45),
    .FUNC_DIS_VAL   (8'h49),
    .RESET_CYCLES   (RC),
    .SUSPEND_CYCLES (SC),
    .CNT_W          (18),
    .REG_TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .usb_enable  (usb_enable),
    .line_state  (line_state),
    .usb_reset   (usb_reset),
    .usb_suspend (usb_suspend),
    .busy        (busy),
    .reg_error   (reg_error),
    .reg_en      (reg_en),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_din     (reg_din),
    .reg_rdy     (reg_rdy),
    .reg_dout    (reg_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic chk_log(string nm, logic [15:0] exp[$]);
    chk({nm, "_len"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      chk(nm, {16'h0, obs[i]}, {16'h0, exp[i]});
  endtask

  task automatic wait_busy(bit val, int max);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      if (busy == val) hit = 1'b1;
    end
    if (!hit) chk("wait_busy_timeout", 0, 1);
  endtask

  task automatic wait_reg_en(int max);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      if (reg_en) hit = 1'b1;
    end
    if (!hit) chk("wait_reg_en_timeout", 0, 1);
  endtask

  // Model: link phase plus a queue of the writes still owed.
  task automatic model_clear();
    m_link     = L_OFF;
    m_enabling = 1'b0;
    m_q.delete();
    m_wph      = 0;
    m_wt       = 0;
    m_cur      = '0;
    m_run      = 0;
    m_prev     = 2'b00;
    m_ureset   = 1'b1;
    m_susp     = 1'b0;
    m_err      = 1'b0;
  endtask

  task automatic model_step();
    int ol;
    bit done_now;
    ol       = m_link;
    done_now = (m_wph == 3);
    m_ureset = !(ol == L_IDLE || ol == L_SUSP);
    m_susp   = (ol == L_SUSP);
    case (m_wph)
      0: if (ol == L_SEQ) begin
        m_wph = 1;
        m_cur = m_q[0];
      end
      1: begin
        m_wph = 2;
        m_wt  = 0;
      end
      2: begin
        if (reg_rdy) m_wph = 3;
        else if (TO_EN && m_wt == TO - 1) begin
          m_wph = 1;
          m_err = 1'b1;
        end else m_wt++;
      end
      default: m_wph = 0;
    endcase
    case (ol)
      L_OFF: if (usb_enable) begin
        m_enabling = 1'b1;
        m_q        = en_list;
        m_link     = L_SEQ;
      end
      L_SEQ: if (done_now) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          if (!m_enabling) m_link = L_OFF;
          else if (usb_enable) m_link = L_RST;
          else begin
            m_enabling = 1'b0;
            m_q        = dis_list;
          end
        end
      end
      default: begin
        if (!usb_enable) begin
          m_enabling = 1'b0;
          m_q        = dis_list;
          m_link     = L_SEQ;
        end else if (ol == L_RST) begin
          if (line_state == 2'b01) m_link = L_IDLE;
        end else if (ol == L_SUSP && line_state == 2'b10) begin
          m_link = L_IDLE;
        end else if (line_state == 2'b00 && m_run >= RC) begin
          m_link = L_RST;
        end else if (ol == L_IDLE && line_state == 2'b01 &&
                     m_run >= SC) begin
          m_link = L_SUSP;
        end
      end
    endcase
    if ((ol == L_IDLE || ol == L_SUSP) && line_state == m_prev)
      m_run++;
    else
      m_run = 0;
    m_prev = line_state;
  endtask

  initial model_clear();

  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else     model_step();
  end

  always @(negedge clk) begin
    chk("busy", busy, m_link == L_SEQ);
    chk("usb_reset", usb_reset, m_ureset);
    chk("usb_suspend", usb_suspend, m_susp);
    chk("reg_en", reg_en, m_wph == 1);
    chk("reg_we", reg_we, m_wph == 1);
    chk("reg_error", reg_error, m_err);
    if (m_wph == 1) begin
      chk("reg_addr", reg_addr, m_cur[15:8]);
      chk("reg_din", reg_din, m_cur[7:0]);
    end
    if (reg_en) obs.push_back({reg_addr, reg_din});
  end

  // PHY responder; early mode also pulses reg_rdy during the strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (reg_en && !hold_rdy) begin
        if (early_rdy) begin
          reg_rdy = 1'b1;
          @(posedge clk);
          #1 reg_rdy = 1'b0;
        end else begin
          @(posedge clk);
        end
        #1 reg_rdy = 1'b1;
        @(posedge clk);
        #1 reg_rdy = 1'b0;
      end
    end
  end

  initial begin
    int n;
    bit hit;

    repeat (3) @(negedge clk);
    chk("rst_usb_reset", usb_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_reg_en", reg_en, 0);
    chk("rst_suspend", usb_suspend, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // enable with bus held in SE0
    line_state = 2'b00;
    early_rdy  = 1'b1;
    obs.delete();
    repeat (2) @(negedge clk);
    usb_enable = 1'b1;
    wait_busy(1, 20);
    wait_busy(0, 200);
    early_rdy = 1'b0;
    chk_log("enable_seq", '{16'h0A00, 16'h0B11, 16'h0445});
    repeat (3) @(negedge clk);
    chk("hold_reset", usb_reset, 1);
    @(posedge clk);
    #1 line_state = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("reset_lag", usb_reset, 1);
    @(negedge clk);
    chk("reset_fall", usb_reset, 0);

    // SE0 one short of the threshold
    @(posedge clk);
    #1 line_state = 2'b00;
    repeat (149) @(posedge clk);
    #1 line_state = 2'b01;
    repeat (5) @(negedge clk);
    chk("se0_149_idle", usb_reset, 0);

    // full bus reset
    @(posedge clk);
    #1 line_state = 2'b00;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 300) begin
      @(negedge clk);
      n++;
      if (usb_reset) hit = 1'b1;
    end
    chk("se0_latency", n, 154);
    @(posedge clk);
    #1 line_state = 2'b01;
    n = 0;
    while (usb_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reset_exit", usb_reset, 0);

    // suspend then one-cycle resume K
    n = 0;
    while (!usb_suspend && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("suspend_set", usb_suspend, 1);
    @(posedge clk);
    #1 line_state = 2'b10;
    @(posedge clk);
    #1 line_state = 2'b01;
    @(posedge clk);
    @(negedge clk);
    chk("resume_clr", usb_suspend, 0);

    // plain disable from IDLE
    obs.delete();
    usb_enable = 1'b0;
    wait_busy(1, 20);
    wait_busy(0, 200);
    chk_log("disable_seq", '{16'h0A00, 16'h0B11, 16'h0449});

    // disable raced against the enabling function write
    obs.delete();
    usb_enable = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (reg_en && reg_addr == 8'h04) hit = 1'b1;
    end
    chk("race_reach", hit, 1);
    usb_enable = 1'b0;
    wait_busy(0, 200);
    chk_log("race_seq", '{16'h0A00, 16'h0B11, 16'h0445,
                          16'h0A00, 16'h0B11, 16'h0449});
    repeat (3) @(negedge clk);
    chk("race_disc_busy", busy, 0);

    // reset while waiting for reg_rdy
    hold_rdy   = 1'b1;
    usb_enable = 1'b1;
    wait_reg_en(20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_reg_en", reg_en, 0);
    chk("midrst_usb_reset", usb_reset, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    hold_rdy = 1'b0;
    obs.delete();
    wait_busy(1, 20);
    wait_busy(0, 200);
    chk_log("restart_seq", '{16'h0A00, 16'h0B11, 16'h0445});
    repeat (4) @(negedge clk);

`ifdef USB_LINK_REG_TIMEOUT_EN
    hold_rdy   = 1'b1;
    usb_enable = 1'b0;
    wait_reg_en(20);
    repeat (8) @(negedge clk);
    chk("to_not_yet", reg_error, 0);
    #1 hold_rdy = 1'b0;
    @(negedge clk);
    chk("to_error", reg_error, 1);
    chk("to_retry_en", reg_en, 1);
    chk("to_retry_addr", reg_addr, 8'h0A);
    wait_busy(0, 300);
    chk("to_sticky", reg_error, 1);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

endmodule
